fp_accum_seq: RTL and testbench

//  Upstream sequencer for the addsub FP32 adder. Accepts a stream of IEEE-754 single-precision operands

---
 rtl/fp_accum_seq.sv | 100 ++++++++++
 tb/tb_fp_accum_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: buffers grouped FP32 operands and chains them through an external adder, one sum per group.
module fp_accum_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        add_start,
  output logic        add_serv,
  input  logic        add_busy,
  input  logic        add_done,
  input  logic [31:0] add_result,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [31:0] sum_data,
  output logic        timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [31:0]   acc;
  logic [WW-1:0] wdog;
  logic          last_q, empty, push, pop, go;
  logic [32:0]   head;

  assign empty     = count == '0;
  assign in_ready  = count != DEPTH;
  assign push      = in_valid & in_ready;
  assign head      = mem[rd_ptr];
  assign go        = state == ISSUE && !empty && !add_busy;
  assign pop       = (state == IDLE && !empty) || go;
  assign sum_valid = state == OUT;
  assign add_serv  = 1'b0;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_last, in_data};

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state       <= IDLE;
      acc         <= '0;
      op1         <= '0;
      op2         <= '0;
      add_start   <= 1'b0;
      sum_data    <= '0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      last_q      <= 1'b0;
    end else begin
      add_start <= 1'b0;
      case (state)
        IDLE: if (!empty) begin
          acc   <= head[31:0];
          state <= head[32] ? OUT : ISSUE;
          if (head[32]) sum_data <= head[31:0];
        end
        ISSUE: if (go) begin
          op1       <= acc;
          op2       <= head[31:0];
          last_q    <= head[32];
          add_start <= 1'b1;
          wdog      <= '0;
          state     <= WAIT;
        end
        // a silent adder is treated as having answered with the accumulator unchanged
        WAIT: if (add_done || wdog == WD_MAX) begin
          if (add_done) acc <= add_result;
          else timeout_err <= 1'b1;
          if (last_q) sum_data <= add_done ? add_result : acc;
          state <= last_q ? OUT : ISSUE;
        end else wdog <= wdog + 1'b1;
        default: if (sum_ready) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: directed checks of fp_accum_seq against a table-driven adder stub.
module tb_fp_accum_seq;
  logic        clk = 1'b0, n_rst = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, sum_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        add_busy = 1'b0, add_done = 1'b0;
  logic [31:0] add_result = '0;
  logic        in_ready, add_start, add_serv, sum_valid, timeout_err;
  logic [31:0] op1, op2, sum_data;
  int          checks = 0, errors = 0, starts = 0, s0 = 0, cnt = 0;
  bit          respond = 1'b1;
  logic [31:0] sa, sb;

  fp_accum_seq #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op1(op1), .op2(op2), .add_start(add_start), .add_serv(add_serv),
    .add_busy(add_busy), .add_done(add_done), .add_result(add_result), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .sum_data(sum_data), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lut(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40200000 && b == 32'h40600000) return 32'h40C00000;
    if (a == 32'h40C00000 && b == 32'h40300000) return 32'h410C0000;
    if (a == 32'hC61C4238 && b == 32'h461C4238) return 32'h00000000;
    return 32'hDEADBEEF;
  endfunction

  // adder stub with 3-cycle latency, driven away from the rising edge
  always @(negedge clk) begin
    if (!n_rst) begin
      cnt = 0;
      add_busy = 1'b0;
      add_done = 1'b0;
    end else begin
      add_done = 1'b0;
      if (add_start) begin
        starts++;
        if (respond) begin
          cnt = 3;
          add_busy = 1'b1;
          sa = op1;
          sb = op2;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          add_done = 1'b1;
          add_busy = 1'b0;
          add_result = lut(sa, sb);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!sum_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!sum_valid) check(tag, {31'b0, sum_valid}, 32'd1);
  endtask

  task automatic get_sum(input string tag, input logic [31:0] exp);
    wait_valid(tag);
    check(tag, sum_data, exp);
    sum_ready = 1'b1;
    @(posedge clk);
    #1 sum_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_sum_valid", {31'b0, sum_valid}, 32'd0);
    check("rst_add_start", {31'b0, add_start}, 32'd0);
    check("rst_timeout", {31'b0, timeout_err}, 32'd0);
    check("rst_sum_data", sum_data, 32'd0);
    check("rst_op1", op1, 32'd0);
    n_rst = 1'b1;

    s0 = starts;
    push(32'h40200000, 1'b0);
    push(32'h40600000, 1'b1);
    get_sum("sum2", 32'h40C00000);
    check("starts2", starts - s0, 32'd1);

    s0 = starts;
    push(32'h40200000, 1'b0);
    push(32'h40600000, 1'b0);
    push(32'h40300000, 1'b1);
    get_sum("sum3", 32'h410C0000);
    check("starts3", starts - s0, 32'd2);

    push(32'hC61C4238, 1'b0);
    push(32'h461C4238, 1'b1);
    get_sum("sum_cancel", 32'h00000000);
    s0 = starts;
    push(32'hC61C4238, 1'b1);
    get_sum("sum_single", 32'hC61C4238);
    check("starts_single", starts - s0, 32'd0);

    push(32'h40200000, 1'b0);
    push(32'h40600000, 1'b1);
    wait_valid("bp_a_valid");
    push(32'h40200000, 1'b0);
    push(32'h40600000, 1'b0);
    push(32'h40300000, 1'b1);
    push(32'hC61C4238, 1'b0);
    @(negedge clk);
    check("bp_full", {31'b0, in_ready}, 32'd0);
    repeat (20) @(negedge clk);
    check("bp_hold_valid", {31'b0, sum_valid}, 32'd1);
    check("bp_hold_data", sum_data, 32'h40C00000);
    fork
      begin
        push(32'h461C4238, 1'b1);
        push(32'h3F800000, 1'b1);
      end
      begin
        get_sum("bp_a", 32'h40C00000);
        get_sum("bp_b", 32'h410C0000);
        get_sum("bp_c", 32'h00000000);
        get_sum("bp_d", 32'h3F800000);
      end
    join

    respond = 1'b0;
    push(32'h40200000, 1'b0);
    push(32'h40600000, 1'b1);
    begin
      int n = 0;
      @(negedge clk);
      while (!add_start && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("to_start", {31'b0, add_start}, 32'd1);
    end
    repeat (63) @(negedge clk);
    check("to_early", {31'b0, timeout_err}, 32'd0);
    @(negedge clk);
    check("to_set", {31'b0, timeout_err}, 32'd1);
    get_sum("to_sum", 32'h40200000);
    check("to_sticky", {31'b0, timeout_err}, 32'd1);

    push(32'h40200000, 1'b0);
    push(32'h40600000, 1'b0);
    push(32'h40300000, 1'b0);
    push(32'h3F800000, 1'b0);
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_sum_valid", {31'b0, sum_valid}, 32'd0);
    check("mid_timeout", {31'b0, timeout_err}, 32'd0);
    check("mid_op1", op1, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    respond = 1'b1;
    s0 = starts;
    push(32'h3F800000, 1'b1);
    get_sum("post_rst_sum", 32'h3F800000);
    check("post_rst_starts", starts - s0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
